// File: rtl/ifid_hazard_if.sv
// IF/ID pipeline register bus: fetch-side inputs, hazard-unit inputs from
// ID/EX and EX resolution, and the IF/ID outputs plus PC/bubble controls.
interface ifid_hazard_if;
    logic [31:0] inst_in;
    logic [31:0] adder1_in;
    logic        idex_mem_read;
    logic [4:0]  idex_Rt;
    logic        branch_taken;
    logic        jump;
    logic        clr_stats;
    logic [31:0] inst_out;
    logic [31:0] adder1_out;
    logic        valid_out;
    logic        pc_write;
    logic        bubble;
    logic [15:0] stall_count;

    // Driver side (fetch/decode environment)
    modport master (
        output inst_in, adder1_in, idex_mem_read, idex_Rt,
               branch_taken, jump, clr_stats,
        input  inst_out, adder1_out, valid_out, pc_write, bubble, stall_count
    );

    // Register/hazard block side
    modport slave (
        input  inst_in, adder1_in, idex_mem_read, idex_Rt,
               branch_taken, jump, clr_stats,
        output inst_out, adder1_out, valid_out, pc_write, bubble, stall_count
    );
endinterface

// File: rtl/ifid_hazard.sv
// IF/ID pipeline register with load-use hazard detection, branch/jump flush
// and a saturating stall-cycle counter.
module ifid_hazard (
    input  logic          clk,
    input  logic          rst,
    ifid_hazard_if.slave  bus
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        rt_nonzero;
    logic        src_match;
    logic        hazard;
    logic        redirect;
    logic        flush;

    // Decode the source fields of the instruction currently in ID
    always_comb begin
        id_rs = inst_q[25:21];
        id_rt = inst_q[20:16];
    end

    // Load-use hazard and flush; an invalid (flushed) slot never stalls
    always_comb begin
        rt_nonzero = (bus.idex_Rt != 5'd0);
        src_match  = (bus.idex_Rt == id_rs) || (bus.idex_Rt == id_rt);
        hazard     = valid_q && bus.idex_mem_read && rt_nonzero && src_match;
        redirect   = bus.branch_taken || bus.jump;
        flush      = redirect && !hazard;
    end

    // Next IF/ID contents: stall holds, flush empties the slot, else capture
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (hazard) begin
            inst_d  = inst_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (flush) begin
            inst_d  = '0;
            pc4_d   = bus.adder1_in;
            valid_d = 1'b0;
        end else begin
            inst_d  = bus.inst_in;
            pc4_d   = bus.adder1_in;
            valid_d = 1'b1;
        end
    end

    // Stall counter next value: clear wins, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_stats) begin
            cnt_d = '0;
        end else if (hazard && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // IF/ID register state, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Stall statistics register, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output drive; pc_write/bubble are purely combinational from hazard
    always_comb begin
        bus.inst_out    = inst_q;
        bus.adder1_out  = pc4_q;
        bus.valid_out   = valid_q;
        bus.pc_write    = !hazard;
        bus.bubble      = hazard;
        bus.stall_count = cnt_q;
    end

endmodule

// File: doc/ifid_hazard.md
IFID_HAZARD -- requirements
Module: ifid_hazard

Interface
REQ-001 The block SHALL have one clock and use an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock shared with all pipeline registers.
REQ-003 rst  in  1  reset; asynchronous assertion when low, synchronous release with clk.
REQ-004 inst_in  in  32  fetched instruction from instruction memory.
REQ-005 adder1_in  in  32  PC+4 from the fetch adder.
REQ-006 idex_mem_read  in  1  mem_read of the instruction now in ID/EX (ID/EX control register output).
REQ-007 idex_Rt  in  5  Rt field of the instruction now in ID/EX.
REQ-008 branch_taken  in  1  taken branch resolved in ID this cycle.
REQ-009 jump  in  1  jump decoded in ID this cycle.
REQ-010 clr_stats  in  1  synchronous clear of stall_count.
REQ-011 inst_out  out  32  instruction held in IF/ID; it feeds decode, the register file and the ID/EX register (Rs, Rt, Rd, immediate).
REQ-012 adder1_out  out  32  PC+4 held in IF/ID; it feeds the ID/EX register adder1 input.
REQ-013 valid_out  out  1  set when inst_out holds a real (non-flushed) instruction.
REQ-014 pc_write  out  1  PC load enable; low freezes the PC.
REQ-015 bubble  out  1  when high, the ID-stage control mux SHALL drive all-zero controls into the ID/EX control register.
REQ-016 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-017 Decode fields: id_rs = inst_out[25:21] and id_rt = inst_out[20:16].
REQ-018 Load-use hazard (combinational) SHALL be: valid_out & idex_mem_read & (idex_Rt != 0) & ((idex_Rt == id_rs) | (idex_Rt == id_rt)).
REQ-019 pc_write SHALL equal !hazard, and bubble SHALL equal hazard, both combinationally in the same cycle; there is no register in this path.
REQ-020 flush SHALL equal (branch_taken | jump) & !hazard, so stall has priority and a branch or jump is ignored during a stall cycle.
REQ-021 On each rising edge with rst high, the priority order SHALL be:
  - hazard: hold inst_out, adder1_out and valid_out.
  - otherwise, if flush: inst_out <= 32'd0, valid_out <= 0, adder1_out <= adder1_in.
  - otherwise: inst_out <= inst_in, adder1_out <= adder1_in, valid_out <= 1.
REQ-022 A load-use stall SHALL last exactly one cycle. On the next edge the bubble has moved into ID/EX (idex_mem_read = 0), so the hazard clears unless new ID/EX values re-trigger it.
REQ-023 A flushed slot (valid_out = 0) SHALL never raise a hazard, even if inst_out bits match.
REQ-024 stall_count SHALL increment by 1 on each edge where the hazard is high.
  - It SHALL saturate at 16'hFFFF with no wrap.
  - clr_stats SHALL take priority over increment and load 0.
REQ-025 Latency: inst_in and adder1_in SHALL appear on the outputs one edge after capture, with no added delay.

Reset
REQ-026 While rst is low, outputs SHALL be asynchronously forced to: inst_out = 0, adder1_out = 0, valid_out = 0, stall_count = 0.
REQ-027 pc_write and bubble SHALL follow REQ-019 during reset; since valid_out = 0, they read 1 and 0.
REQ-028 The first edge after rst rises SHALL capture normally; reset asserted mid-stall SHALL drop the held instruction.

Verification
REQ-029 Normal flow: inst_in = 32'h012A4020 (add $8,$9,$10), adder1_in = 32'h4 -> after one edge inst_out = 32'h012A4020, adder1_out = 4, valid_out = 1, pc_write = 1.
REQ-030 Load-use stall:
  - Setup: ID holds 32'h01095020 (rs = 8, rt = 9); idex_mem_read = 1, idex_Rt = 8.
  - Expected: bubble = 1 and pc_write = 0 that cycle; outputs are held across the edge; stall_count goes 0 -> 1.
  - Next cycle with idex_mem_read = 0: bubble = 0.
REQ-031 No false stall: idex_Rt = 0 or idex_mem_read = 0 with matching fields -> bubble stays 0.
REQ-032 Flush: branch_taken = 1, no hazard -> after the edge inst_out = 0, valid_out = 0; the next cycle shows hazard = 0 even with idex_mem_read = 1 and idex_Rt = 0.
REQ-033 Stall beats branch: hazard and branch_taken both 1 -> inst_out held, valid_out stays 1, no flush.
REQ-034 Reset and counter:
  - Force stall_count to 16'hFFFF and keep the hazard high -> it stays at FFFF.
  - clr_stats with hazard -> 0.
  - rst low mid-cycle -> all registered outputs are 0 immediately, without waiting for a clock edge.
